// File: rtl/mips_lsu_bus.sv
// Load/store unit front end: turns one CPU byte/half/word/dword access into one Avalon-MM transfer.
// Latency: strobe one cycle after accept, response 2+N cycles after accept (N = stall cycles); errors respond after 1.
// Backpressure: req_ready only in IDLE (one access outstanding); waitrequest holds the bus phase, optional timeout abort.
module mips_lsu_bus #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_signed,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   resp_valid,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic [1:0]             resp_err,
  output logic [ADDR_W-1:0]      address,
  output logic                   read,
  output logic                   write,
  output logic [DATA_W-1:0]      writedata,
  output logic [DATA_W/8-1:0]    byteenable,
  input  logic                   waitrequest,
  input  logic [DATA_W-1:0]      readdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned LB    = $clog2(BE_W);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value at which the next stalled cycle is the TIMEOUT-th one.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;
  localparam logic [1:0] ERR_SIZE  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                read_q, read_d, write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LB-1:0]       lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [1:0]          resp_err_q, resp_err_d;

  // Low 2^size lanes set; shifted into position by the caller.
  function automatic logic [BE_W-1:0] lanes_of(input logic [1:0] size);
    logic [BE_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (i < (1 << size)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Expand a per-byte enable into a per-bit mask.
  function automatic logic [DATA_W-1:0] bytes_to_bits(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(BE_W); i++) begin
      r[i*8 +: 8] = {8{be[i]}};
    end
    return r;
  endfunction

  logic [LB+2:0]       req_sh;
  logic [BE_W-1:0]     req_be;
  logic [DATA_W-1:0]   req_wd;
  logic                req_illegal;
  logic                req_misalign;
  logic [LB+2:0]       ld_sh;
  logic [DATA_W-1:0]   ld_raw, ld_mask, ld_data;
  logic                ld_sign;

  // Request decode: lane placement of store data and the two error checks.
  always_comb begin
    req_sh      = {req_addr[LB-1:0], 3'b000};
    req_be      = lanes_of(req_size) << req_addr[LB-1:0];
    req_wd      = (req_wdata << req_sh) & bytes_to_bits(req_be);
    req_illegal = (req_size == 2'd3) && (DATA_W < 64);
    unique case (req_size)
      2'd0:    req_misalign = 1'b0;
      2'd1:    req_misalign = req_addr[0];
      2'd2:    req_misalign = |req_addr[1:0];
      default: req_misalign = |req_addr[2:0];
    endcase
  end

  // Load alignment: bring the addressed lane to bit 0, keep 2^size bytes, then extend.
  always_comb begin
    ld_sh   = {lane_q, 3'b000};
    ld_raw  = readdata >> ld_sh;
    ld_mask = bytes_to_bits(lanes_of(size_q));
    // mask ^ (mask >> 1) isolates the top bit of the access, i.e. its sign bit
    ld_sign = signed_q & (|(ld_raw & (ld_mask ^ (ld_mask >> 1))));
    ld_data = (ld_raw & ld_mask) | (ld_sign ? ~ld_mask : '0);
  end

  // Next-state and registered-output logic of the IDLE/BUS/RESP controller.
  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    lane_d       = lane_q;
    size_d       = size_q;
    signed_d     = signed_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_illegal) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = ERR_SIZE;
            resp_rdata_d = '0;
          end else if (req_misalign) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = ERR_ALIGN;
            resp_rdata_d = '0;
          end else begin
            state_d  = S_BUS;
            read_d   = ~req_write;
            write_d  = req_write;
            addr_d   = {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
            be_d     = req_be;
            wdata_d  = req_wd;
            lane_d   = req_addr[LB-1:0];
            size_d   = req_size;
            signed_d = req_signed;
            cnt_d    = '0;
          end
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          state_d      = S_RESP;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = ERR_OK;
          resp_rdata_d = write_q ? '0 : ld_data;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d      = S_RESP;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = ERR_TMO;
          resp_rdata_d = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and aborts any bus access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      lane_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign address    = addr_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;

endmodule
